// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic intersection controller: lamp codes,
// FSM state encoding and the per-approach lamp decode helper.
package traffic_pkg;

    localparam logic [1:0] TL_RED    = 2'b10;
    localparam logic [1:0] TL_YELLOW = 2'b11;
    localparam logic [1:0] TL_GREEN  = 2'b01;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'b00,
        ST_GREEN   = 2'b01,
        ST_YELLOW  = 2'b10
    } tl_state_t;

    function automatic logic [1:0] tl_lamp(input tl_state_t st, input logic sel);
        logic [1:0] code;
        code = TL_RED;
        case (st)
            ST_GREEN: begin
                if (sel) code = TL_GREEN;
                else     code = TL_RED;
            end
            ST_YELLOW: begin
                if (sel) code = TL_YELLOW;
                else     code = TL_RED;
            end
            default: code = TL_RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin scan: first set request after index `last`,
// wrapping modulo N. `idx` holds `last` when nothing is requesting.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Priority scan starting one past the last served index
    always_comb begin
        int cand;
        valid = 1'b0;
        idx   = last;
        cand  = 0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(last) + off) % N;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// N-approach round-robin traffic-light controller with all-red clearance.
// Optional green extension for a lone requester: define TL_GREEN_EXT_EN.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR       = 2,
    parameter int GREEN_CYC     = 8,
    parameter int YELLOW_CYC    = 2,
    parameter int ALLRED_CYC    = 1,
    parameter int MAX_GREEN_CYC = 16,
    parameter int CNT_W         = 8
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           en,
    input  logic [NUM_DIR-1:0]                             req,
    output logic [2*NUM_DIR-1:0]                           light,
    output logic [((NUM_DIR > 1) ? $clog2(NUM_DIR) : 1)-1:0] active_dir,
    output logic                                           phase_done
);

    localparam int DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

    if (NUM_DIR < 2) begin : g_chk_dir
        $error("NUM_DIR must be at least 2");
    end
    if (GREEN_CYC < 1 || YELLOW_CYC < 1 || ALLRED_CYC < 1) begin : g_chk_dur
        $error("dwell parameters must be at least 1");
    end
    if (MAX_GREEN_CYC < GREEN_CYC) begin : g_chk_max
        $error("MAX_GREEN_CYC must be >= GREEN_CYC");
    end
    if (MAX_GREEN_CYC > (1 << CNT_W) || GREEN_CYC > (1 << CNT_W)) begin : g_chk_w
        $error("CNT_W too narrow for dwell parameters");
    end

    tl_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIR_W-1:0]     active_dir_q, active_dir_d;
    logic [2*NUM_DIR-1:0] light_q, light_d;
    logic                 phase_done_q, phase_done_d;
    logic                 arb_valid_s;
    logic [DIR_W-1:0]     arb_idx_s;
    logic                 extend_s;

    rr_arbiter #(
        .N     (NUM_DIR),
        .IDX_W (DIR_W)
    ) u_arb (
        .req   (req),
        .last  (active_dir_q),
        .valid (arb_valid_s),
        .idx   (arb_idx_s)
    );

`ifdef TL_GREEN_EXT_EN
    logic [CNT_W-1:0]   elapsed_q, elapsed_d;
    logic [NUM_DIR-1:0] own_s;

    // Extend only while the served approach is the sole requester and under the cap
    always_comb begin
        own_s    = NUM_DIR'(1) << active_dir_q;
        extend_s = req[active_dir_q] && ((req & ~own_s) == {NUM_DIR{1'b0}})
                   && (elapsed_q < CNT_W'(MAX_GREEN_CYC - 1));
    end

    // Count green clocks already spent in the current green phase
    always_comb begin
        if (state_d == ST_GREEN && state_q == ST_GREEN) begin
            elapsed_d = elapsed_q + CNT_W'(1);
        end else begin
            elapsed_d = {CNT_W{1'b0}};
        end
    end

    // Elapsed-green register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elapsed_q <= {CNT_W{1'b0}};
        end else begin
            elapsed_q <= elapsed_d;
        end
    end
`else
    // Green is fixed-length in this build
    always_comb begin
        extend_s = 1'b0;
    end
`endif

    // Next-state, dwell counter and grant selection
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        active_dir_d = active_dir_q;
        phase_done_d = 1'b0;
        if (!en) begin
            state_d = ST_ALL_RED;
            cnt_d   = CNT_W'(ALLRED_CYC - 1);
        end else begin
            case (state_q)
                ST_ALL_RED: begin
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (arb_valid_s) begin
                        state_d      = ST_GREEN;
                        cnt_d        = CNT_W'(GREEN_CYC - 1);
                        active_dir_d = arb_idx_s;
                    end else begin
                        state_d = ST_ALL_RED;
                    end
                end
                ST_GREEN: begin
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (extend_s) begin
                        state_d = ST_GREEN;
                    end else begin
                        state_d = ST_YELLOW;
                        cnt_d   = CNT_W'(YELLOW_CYC - 1);
                    end
                end
                ST_YELLOW: begin
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d      = ST_ALL_RED;
                        cnt_d        = CNT_W'(ALLRED_CYC - 1);
                        phase_done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_ALL_RED;
                    cnt_d   = CNT_W'(ALLRED_CYC - 1);
                end
            endcase
        end
    end

    // Lamps are decoded from the next state so they change on the state edge
    always_comb begin
        light_d = {2*NUM_DIR{1'b0}};
        for (int i = 0; i < NUM_DIR; i++) begin
            light_d[2*i +: 2] = tl_lamp(state_d, int'(active_dir_d) == i);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ALL_RED;
            cnt_q        <= {CNT_W{1'b0}};
            active_dir_q <= DIR_W'(NUM_DIR - 1);
            light_q      <= {NUM_DIR{TL_RED}};
            phase_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            active_dir_q <= active_dir_d;
            light_q      <= light_d;
            phase_done_q <= phase_done_d;
        end
    end

    assign light      = light_q;
    assign active_dir = active_dir_q;
    assign phase_done = phase_done_q;

endmodule
